// File: rtl/gcn_pkg.sv
// gcn_pkg
//   Shared sizing constants and types for the GCN memory server.
//   - BW / N_ELEM  : element width and elements per matrix row
//   - N_FM / N_WM  : feature-matrix and weight-matrix row counts
//   - N_OUT / CLS_W: result entries and class-index width
//   - row_t        : one packed matrix row (element 0 in the MSBs)
//   - srv_state_t  : run sequencer states
package gcn_pkg;

  localparam int BW     = 16;
  localparam int N_ELEM = 3;
  localparam int N_FM   = 6;
  localparam int N_WM   = 3;
  localparam int N_OUT  = 6;
  localparam int CLS_W  = 3;
  localparam int ROW_W  = N_ELEM * BW;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } srv_state_t;

endpackage

// File: rtl/gcn_rd_pipe.sv
// gcn_rd_pipe
//   LAT-stage valid/data delay line for the read path.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     in_valid      : read request accepted this cycle
//     in_data       : read data captured with the request
//     out_valid     : in_valid delayed by exactly LAT cycles
//     out_data      : matching data; holds its last value while out_valid=0
//   Handshake: no back-pressure. A beat entering with in_valid=1 leaves
//   LAT cycles later; one beat per cycle is sustained.
module gcn_rd_pipe #(
  parameter int LAT = 1,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] v_q;
  logic [W-1:0]   d_q [LAT];

  // Data stages only load when a valid beat arrives, so the last stage
  // naturally holds the previous beat during idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < LAT; k++) d_q[k] <= '0;
    end else begin
      v_q[0] <= in_valid;
      if (in_valid) d_q[0] <= in_data;
      for (int k = 1; k < LAT; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) d_q[k] <= d_q[k-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_data  = d_q[LAT-1];

endmodule

// File: rtl/gcn_mem_server.sv
// gcn_mem_server
//   Memory-side responder for the GCN datapath: holds the feature matrix
//   (FM) and weight matrix (WM), answers row reads after RD_LAT cycles,
//   captures class results and sequences a run IDLE -> SERVE -> DONE.
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     ld_valid/ld_sel/ld_addr/ld_data : host row preload (sel 0=FM, 1=WM)
//     ld_ready                      : preload written this cycle
//     go                            : host run-start pulse (IDLE only)
//     gcn_start                     : run enable to the GCN (state SERVE)
//     rd_en/rd_addr_fm/rd_addr_wm   : GCN row read request
//     rd_features/rd_weights/rd_valid : read response, RD_LAT cycles later
//     wr_en/wr_addr/wr_data         : GCN class-result write (SERVE only)
//     res_addr/res_data             : combinational host readback
//     run_done                      : 1-cycle pulse, all results captured
//     busy                          : run in progress
//     err                           : sticky error, cleared only by rst
//   Handshake: ld_ready is high in exactly the cycles where ld_valid is
//   high, the server is IDLE and the row index is in range; the row is
//   written at that clock edge. Reads and writes have no back-pressure.
module gcn_mem_server
  import gcn_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic             ld_sel,
  input  logic [2:0]       ld_addr,
  input  logic [ROW_W-1:0] ld_data,
  output logic             ld_ready,
  input  logic             go,
  output logic             gcn_start,
  input  logic             rd_en,
  input  logic [2:0]       rd_addr_fm,
  input  logic [1:0]       rd_addr_wm,
  output logic [ROW_W-1:0] rd_features,
  output logic [ROW_W-1:0] rd_weights,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [CLS_W-1:0] wr_data,
  input  logic [2:0]       res_addr,
  output logic [CLS_W-1:0] res_data,
  output logic             run_done,
  output logic             busy,
  output logic             err
);

  srv_state_t       state, state_next;
  logic             clear_res;

  row_t             fm_mem  [N_FM];
  row_t             wm_mem  [N_WM];
  logic [CLS_W-1:0] res_mem [N_OUT];
  logic [N_OUT-1:0] done_map;
  logic             err_q;

  logic             ld_addr_ok, ld_ok;
  logic             rd_fm_ok, rd_wm_ok;
  logic             wr_addr_ok, wr_ok;
  logic             err_set;
  row_t             rd_fm_word, rd_wm_word;

  // ---------------- request decode ----------------
  assign ld_addr_ok = ld_sel ? (ld_addr < 3'(N_WM)) : (ld_addr < 3'(N_FM));
  assign ld_ok      = ld_valid && (state == IDLE) && ld_addr_ok;
  assign rd_fm_ok   = rd_addr_fm < 3'(N_FM);
  assign rd_wm_ok   = rd_addr_wm < 2'(N_WM);
  assign wr_addr_ok = wr_addr < 3'(N_OUT);
  assign wr_ok      = wr_en && (state == SERVE) && wr_addr_ok;

  assign err_set = (ld_valid && ((state != IDLE) || !ld_addr_ok))
                 || (rd_en && (!rd_fm_ok || !rd_wm_ok))
                 || (wr_en && ((state != SERVE) || !wr_addr_ok));

  // Reads sample the arrays before this edge's preload lands, so a
  // same-cycle load and read of one row returns the old contents.
  assign rd_fm_word = rd_fm_ok ? fm_mem[rd_addr_fm] : '0;
  assign rd_wm_word = rd_wm_ok ? wm_mem[rd_addr_wm] : '0;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear_res  = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_next = SERVE;
          clear_res  = 1'b1;
        end
      end
      // Completion is judged on the registered bitmap, so the write that
      // fills the last entry is captured and DONE follows one cycle later.
      SERVE:   if (&done_map) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == SERVE);
  assign gcn_start = (state == SERVE);
  assign run_done  = (state == DONE);
  assign ld_ready  = ld_ok;
  assign err       = err_q;

  // ---------------- storage ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_FM; i++)  fm_mem[i]  <= '0;
      for (int i = 0; i < N_WM; i++)  wm_mem[i]  <= '0;
      for (int i = 0; i < N_OUT; i++) res_mem[i] <= '0;
      done_map <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_q | err_set;
      if (ld_ok) begin
        if (ld_sel) wm_mem[ld_addr[1:0]] <= ld_data;
        else        fm_mem[ld_addr]      <= ld_data;
      end
      if (clear_res) begin
        for (int i = 0; i < N_OUT; i++) res_mem[i] <= '0;
        done_map <= '0;
      end else if (wr_ok) begin
        res_mem[wr_addr]  <= wr_data;
        done_map[wr_addr] <= 1'b1;
      end
    end
  end

  assign res_data = (res_addr < 3'(N_OUT)) ? res_mem[res_addr] : '0;

  // ---------------- read pipe ----------------
  gcn_rd_pipe #(
    .LAT (RD_LAT),
    .W   (2 * ROW_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_data   ({rd_fm_word, rd_wm_word}),
    .out_valid (rd_valid),
    .out_data  ({rd_features, rd_weights})
  );

endmodule

// File: tb/tb_gcn_mem_server.sv
// tb_gcn_mem_server
//   Directed bench for gcn_mem_server: preload, single and streaming reads,
//   completion, rewrite, error cases and reset mid-run.
module tb_gcn_mem_server;
  import gcn_pkg::*;

  localparam int RD_LAT = 1;
  localparam int N_RD   = N_FM * N_WM;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             ld_valid, ld_sel;
  logic [2:0]       ld_addr;
  logic [ROW_W-1:0] ld_data;
  logic             ld_ready;
  logic             go, gcn_start;
  logic             rd_en;
  logic [2:0]       rd_addr_fm;
  logic [1:0]       rd_addr_wm;
  logic [ROW_W-1:0] rd_features, rd_weights;
  logic             rd_valid;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [CLS_W-1:0] wr_data;
  logic [2:0]       res_addr;
  logic [CLS_W-1:0] res_data;
  logic             run_done, busy, err;

  always #5 clk = ~clk;

  gcn_mem_server #(.RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_sel      (ld_sel),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .go          (go),
    .gcn_start   (gcn_start),
    .rd_en       (rd_en),
    .rd_addr_fm  (rd_addr_fm),
    .rd_addr_wm  (rd_addr_wm),
    .rd_features (rd_features),
    .rd_weights  (rd_weights),
    .rd_valid    (rd_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .run_done    (run_done),
    .busy        (busy),
    .err         (err)
  );

  // ---------------- expected data model ----------------
  function automatic row_t fm_row(input int i);
    return {BW'(i), BW'(i + 1), BW'(i + 2)};
  endfunction

  function automatic row_t wm_row(input int j);
    return {BW'(10 * j + 1), BW'(10 * j + 2), BW'(10 * j + 3)};
  endfunction

  typedef struct {
    logic [2:0] fm;
    logic [1:0] wm;
    row_t       feat;
    row_t       wt;
  } rd_vec_t;

  rd_vec_t rd_tbl [N_RD];

  // ---------------- scoreboard ----------------
  logic [2*ROW_W-1:0] exp_q [$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [2*ROW_W-1:0] act,
                       input logic [2*ROW_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    go = 1'b0; rd_en = 1'b0; rd_addr_fm = '0; rd_addr_wm = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; res_addr = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ld_ready"},  ld_ready,    0);
    check({tag, "_gcn_start"}, gcn_start,   0);
    check({tag, "_rd_valid"},  rd_valid,    0);
    check({tag, "_rd_feat"},   rd_features, 0);
    check({tag, "_rd_wt"},     rd_weights,  0);
    check({tag, "_res_data"},  res_data,    0);
    check({tag, "_run_done"},  run_done,    0);
    check({tag, "_busy"},      busy,        0);
    check({tag, "_err"},       err,         0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic load_row(input logic sel, input logic [2:0] addr, input row_t data);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic write_res(input logic [2:0] addr, input logic [CLS_W-1:0] y);
    wr_en = 1'b1; wr_addr = addr; wr_data = y;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_run();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [2*ROW_W-1:0] exp_beat;
    int beats;
    int rw_addr [6];
    int rw_data [6];

    for (int w = 0; w < N_WM; w++)
      for (int f = 0; f < N_FM; f++) begin
        rd_tbl[w * N_FM + f].fm   = 3'(f);
        rd_tbl[w * N_FM + f].wm   = 2'(w);
        rd_tbl[w * N_FM + f].feat = fm_row(f);
        rd_tbl[w * N_FM + f].wt   = wm_row(w);
      end
    rw_addr = '{1, 1, 0, 2, 3, 4};
    rw_data = '{2, 6, 1, 1, 1, 1};

    idle_inputs();
    rst = 1'b1;
    tick();
    do_reset();
    check_all_zero("reset");

    // Preload FM and WM in IDLE.
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 3'd0; ld_data = fm_row(0);
    #1;
    check("ld_ready_idle", ld_ready, 1);
    tick();
    for (int i = 1; i < N_FM; i++) load_row(1'b0, 3'(i), fm_row(i));
    for (int j = 0; j < N_WM; j++) load_row(1'b1, 3'(j), wm_row(j));

    // Same-cycle load and read of one row returns the old row.
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 3'd2; ld_data = 48'hAAAA_BBBB_CCCC;
    rd_en = 1'b1; rd_addr_fm = 3'd2; rd_addr_wm = 2'd0;
    tick();
    ld_valid = 1'b0;
    check("ld_rd_same_old", rd_features, fm_row(2));
    tick();
    rd_en = 1'b0;
    check("ld_rd_after_new", rd_features, 48'hAAAA_BBBB_CCCC);
    load_row(1'b0, 3'd2, fm_row(2));
    check("err_clean_idle", err, 0);

    // Start a run and do a single read.
    start_run();
    check("go_busy", busy, 1);
    check("go_gcn_start", gcn_start, 1);
    rd_en = 1'b1; rd_addr_fm = 3'd3; rd_addr_wm = 2'd1;
    tick();
    rd_en = 1'b0;
    check("rd1_valid", rd_valid, 1);
    check("rd1_feat", rd_features, {16'd3, 16'd4, 16'd5});
    check("rd1_wt", rd_weights, wm_row(1));
    tick();
    check("rd1_valid_drop", rd_valid, 0);

    // Streaming reads, one beat per cycle.
    beats = 0;
    for (int c = 0; c < N_RD; c++) begin
      rd_en = 1'b1; rd_addr_fm = rd_tbl[c].fm; rd_addr_wm = rd_tbl[c].wm;
      exp_q.push_back({rd_tbl[c].feat, rd_tbl[c].wt});
      tick();
      if (rd_valid) beats++;
      exp_beat = exp_q.pop_front();
      check("stream_data", {rd_features, rd_weights}, exp_beat);
    end
    rd_en = 1'b0;
    check("stream_beats", beats, N_RD);
    tick();
    check("hold_valid", rd_valid, 0);
    check("hold_feat", rd_features, rd_tbl[N_RD-1].feat);
    check("hold_wt", rd_weights, rd_tbl[N_RD-1].wt);

    // Completion: y = 5..0 into addr 0..5.
    for (int a = 0; a < N_OUT; a++) begin
      write_res(3'(a), CLS_W'(5 - a));
      check("cmp_no_done", run_done, 0);
    end
    tick();
    check("cmp_run_done", run_done, 1);
    check("cmp_busy", busy, 0);
    check("cmp_gcn_start", gcn_start, 0);
    res_addr = 3'd2;
    #1;
    check("cmp_res2", res_data, 3);
    tick();
    check("cmp_done_pulse", run_done, 0);
    check("cmp_err", err, 0);

    // Rewrite: addr 1 written twice, completion needs all six distinct.
    start_run();
    for (int k = 0; k < 6; k++) begin
      write_res(3'(rw_addr[k]), CLS_W'(rw_data[k]));
      check("rw_no_done", run_done, 0);
    end
    tick();
    check("rw_still_busy", busy, 1);
    check("rw_still_no_done", run_done, 0);
    write_res(3'd5, 3'd3);
    tick();
    check("rw_run_done", run_done, 1);
    res_addr = 3'd1;
    #1;
    check("rw_res1", res_data, 6);
    tick();

    // Error cases, each from a clean reset.
    do_reset();
    check("e1_err_pre", err, 0);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 3'd7; ld_data = fm_row(1);
    #1;
    check("e1_ld_ready", ld_ready, 0);
    tick();
    ld_valid = 1'b0;
    check("e1_err", err, 1);

    do_reset();
    check("e2_err_pre", err, 0);
    start_run();
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 3'd0; ld_data = fm_row(4);
    #1;
    check("e2_ld_ready", ld_ready, 0);
    tick();
    ld_valid = 1'b0;
    check("e2_err", err, 1);

    do_reset();
    check("e3_err_pre", err, 0);
    load_row(1'b1, 3'd1, wm_row(1));
    rd_en = 1'b1; rd_addr_fm = 3'd6; rd_addr_wm = 2'd1;
    tick();
    rd_en = 1'b0;
    check("e3_rd_valid", rd_valid, 1);
    check("e3_feat_zero", rd_features, 0);
    check("e3_wt", rd_weights, wm_row(1));
    check("e3_err", err, 1);

    do_reset();
    check("e4_err_pre", err, 0);
    write_res(3'd0, 3'd3);
    check("e4_err", err, 1);
    res_addr = 3'd0;
    #1;
    check("e4_res_unchanged", res_data, 0);

    // Reset in the middle of a run.
    do_reset();
    start_run();
    write_res(3'd0, 3'd7);
    write_res(3'd1, 3'd6);
    write_res(3'd2, 3'd5);
    res_addr = 3'd0;
    #1;
    check("mr_res0_before", res_data, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    res_addr = 3'd0;
    #1;
    check_all_zero("mr");
    start_run();
    for (int a = 0; a < N_OUT; a++) write_res(3'(a), CLS_W'(a + 1));
    tick();
    check("mr_run_done", run_done, 1);
    res_addr = 3'd4;
    #1;
    check("mr_res4", res_data, 5);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
